// File: rtl/turbo_ext_interleaver_pkg.sv
// Shared turbo decoder definitions: block geometry, interleaver FSM states
// and the saturation helper shared with the SISO front end.
package turbo_ext_interleaver_pkg;

    localparam int unsigned DATA_SIZE  = 10;
    localparam int unsigned INPUT_SIZE = 5;
    localparam int unsigned BLOCK_SIZE = 3 * (INPUT_SIZE + 2);
    localparam int unsigned ADDR_W     = $clog2(BLOCK_SIZE);
    localparam int unsigned SAT_IN_W   = DATA_SIZE + 4;

    localparam logic signed [SAT_IN_W-1:0] SAT_MAX = SAT_IN_W'((2 ** (INPUT_SIZE - 1)) - 1);
    localparam logic signed [SAT_IN_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic {
        ST_FILL  = 1'b0,
        ST_DRAIN = 1'b1
    } il_state_e;

    // Clamp a wide signed value into the INPUT_SIZE soft-value range.
    function automatic logic signed [INPUT_SIZE-1:0] sat_input(input logic signed [SAT_IN_W-1:0] x);
        if (x > SAT_MAX) begin
            return INPUT_SIZE'(SAT_MAX);
        end else if (x < SAT_MIN) begin
            return INPUT_SIZE'(SAT_MIN);
        end
        return INPUT_SIZE'(x);
    endfunction

endpackage

// File: rtl/turbo_ext_interleaver_if.sv
// Streaming bundle between the SISO output, the extrinsic interleaver and the
// next SISO a-priori input.
interface turbo_ext_interleaver_if;
    import turbo_ext_interleaver_pkg::*;

    logic                         mode_i;
    logic signed [DATA_SIZE-1:0]  llr_i;
    logic signed [INPUT_SIZE-1:0] sys_i;
    logic signed [INPUT_SIZE-1:0] apr_i;
    logic                         in_valid_i;
    logic                         in_ready_o;
    logic signed [INPUT_SIZE-1:0] ext_o;
    logic                         out_valid_o;
    logic                         out_ready_i;
    logic                         out_last_o;
    logic                         busy_o;

    modport master (
        output mode_i, llr_i, sys_i, apr_i, in_valid_i, out_ready_i,
        input  in_ready_o, ext_o, out_valid_o, out_last_o, busy_o
    );

    modport slave (
        input  mode_i, llr_i, sys_i, apr_i, in_valid_i, out_ready_i,
        output in_ready_o, ext_o, out_valid_o, out_last_o, busy_o
    );

endinterface

// File: rtl/turbo_ext_interleaver_pi_gen.sv
// Incremental pi(k) = (STEP*k + OFFSET) mod BLOCK_SIZE generator; one
// add-and-conditional-subtract per advance.
module turbo_pi_gen
    import turbo_ext_interleaver_pkg::*;
#(
    parameter int unsigned STEP   = 5,
    parameter int unsigned OFFSET = 0
) (
    input  logic              clk_p_i,
    input  logic              reset_n_i,
    input  logic              load_i,
    input  logic              adv_i,
    output logic [ADDR_W-1:0] pi_o
);

    localparam int unsigned SUM_W = ADDR_W + 1;

    logic [ADDR_W-1:0] pi_q;
    logic [ADDR_W-1:0] pi_d;
    logic [SUM_W-1:0]  sum_c;

    always_comb begin
        sum_c = {1'b0, pi_q} + SUM_W'(STEP);
        if (sum_c >= SUM_W'(BLOCK_SIZE)) begin
            sum_c = sum_c - SUM_W'(BLOCK_SIZE);
        end
        pi_d = pi_q;
        if (load_i) begin
            pi_d = ADDR_W'(OFFSET);
        end else if (adv_i) begin
            pi_d = sum_c[ADDR_W-1:0];
        end
    end

    always_ff @(posedge clk_p_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            pi_q <= ADDR_W'(OFFSET);
        end else begin
            pi_q <= pi_d;
        end
    end

    assign pi_o = pi_q;

endmodule

// File: rtl/turbo_ext_interleaver.sv
// Extrinsic former plus single-buffer block interleaver: fills one block of
// scaled/saturated extrinsics, then replays it permuted to the next SISO.
module turbo_ext_interleaver
    import turbo_ext_interleaver_pkg::*;
#(
    parameter int unsigned PI_STEP   = 5,
    parameter int unsigned PI_OFFSET = 0
) (
    input  logic                    clk_p_i,
    input  logic                    reset_n_i,
    turbo_ext_interleaver_if.slave  bus_s
);

    localparam int unsigned E_W = DATA_SIZE + 2;

    il_state_e                    state_q, state_d;
    logic [ADDR_W-1:0]            wr_cnt_q, wr_cnt_d;
    logic [ADDR_W-1:0]            rd_cnt_q, rd_cnt_d;
    logic                         mode_q, mode_d;
    logic signed [INPUT_SIZE-1:0] ext_q, ext_d;
    logic                         out_valid_q, out_valid_d;
    logic                         out_last_q, out_last_d;
    logic                         busy_q, busy_d;
    logic                         in_ready_q, in_ready_d;
    logic signed [INPUT_SIZE-1:0] mem_q [0:BLOCK_SIZE-1];

    logic signed [E_W-1:0]        e_c;
    logic signed [SAT_IN_W-1:0]   p_c;
    logic signed [SAT_IN_W-1:0]   s_c;
    logic signed [INPUT_SIZE-1:0] ext_c;
    logic                         accept_c, fill_last_c, load_c, drain_done_c;
    logic                         mode_eff_c, pi_load_c, pi_adv_c;
    logic [ADDR_W-1:0]            wr_addr_c, rd_addr_c, pi_c;

    // Extrinsic = LLR - sys - apr, scaled by 3/4 (floor) and saturated.
    always_comb begin
        e_c   = E_W'(bus_s.llr_i) - E_W'(bus_s.sys_i) - E_W'(bus_s.apr_i);
        p_c   = (SAT_IN_W'(e_c) <<< 1) + SAT_IN_W'(e_c);
        s_c   = p_c >>> 2;
        ext_c = sat_input(s_c);
    end

    assign accept_c     = bus_s.in_valid_i && in_ready_q;
    assign fill_last_c  = (wr_cnt_q == ADDR_W'(BLOCK_SIZE - 1));
    assign load_c       = (state_q == ST_DRAIN) && (!out_valid_q || bus_s.out_ready_i)
                          && (rd_cnt_q < ADDR_W'(BLOCK_SIZE));
    assign drain_done_c = out_valid_q && out_last_q && bus_s.out_ready_i;

    // First beat of a block uses the live mode; later beats the latched one.
    assign mode_eff_c = (wr_cnt_q == '0) ? bus_s.mode_i : mode_q;
    assign wr_addr_c  = mode_eff_c ? pi_c : wr_cnt_q;
    assign rd_addr_c  = mode_q ? rd_cnt_q : pi_c;

    always_ff @(posedge clk_p_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= ST_FILL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_FILL:  if (accept_c && fill_last_c) state_d = ST_DRAIN;
            ST_DRAIN: if (drain_done_c)            state_d = ST_FILL;
        endcase
    end

    always_comb begin
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        mode_d      = mode_q;
        ext_d       = ext_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        busy_d      = busy_q;
        pi_load_c   = 1'b0;
        pi_adv_c    = 1'b0;

        if (accept_c) begin
            if (wr_cnt_q == '0) begin
                mode_d = bus_s.mode_i;
                busy_d = 1'b1;
            end
            wr_cnt_d = wr_cnt_q + ADDR_W'(1);
            pi_adv_c = mode_eff_c;
            if (fill_last_c) begin
                wr_cnt_d  = '0;
                pi_load_c = 1'b1;
            end
        end

        if (load_c) begin
            ext_d       = mem_q[rd_addr_c];
            out_valid_d = 1'b1;
            out_last_d  = (rd_cnt_q == ADDR_W'(BLOCK_SIZE - 1));
            rd_cnt_d    = rd_cnt_q + ADDR_W'(1);
            pi_adv_c    = !mode_q;
        end else if (out_valid_q && bus_s.out_ready_i) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end

        if (drain_done_c) begin
            rd_cnt_d  = '0;
            busy_d    = 1'b0;
            pi_load_c = 1'b1;
        end

        in_ready_d = (state_d == ST_FILL);
    end

    always_ff @(posedge clk_p_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            mode_q      <= 1'b0;
            ext_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            mode_q      <= mode_d;
            ext_q       <= ext_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            in_ready_q  <= in_ready_d;
        end
    end

    // Block buffer has no reset; contents are only read after a full fill.
    always_ff @(posedge clk_p_i) begin
        if (accept_c) begin
            mem_q[wr_addr_c] <= ext_c;
        end
    end

    turbo_pi_gen #(
        .STEP   (PI_STEP),
        .OFFSET (PI_OFFSET)
    ) u_pi_gen (
        .clk_p_i   (clk_p_i),
        .reset_n_i (reset_n_i),
        .load_i    (pi_load_c),
        .adv_i     (pi_adv_c),
        .pi_o      (pi_c)
    );

    assign bus_s.in_ready_o  = in_ready_q;
    assign bus_s.ext_o       = ext_q;
    assign bus_s.out_valid_o = out_valid_q;
    assign bus_s.out_last_o  = out_last_q;
    assign bus_s.busy_o      = busy_q;

endmodule

// File: tb/tb_turbo_ext_interleaver.sv
// Directed bench for turbo_ext_interleaver: arithmetic, interleave order,
// round trip, backpressure, input gaps and reset mid-drain.
module tb_turbo_ext_interleaver;
    import turbo_ext_interleaver_pkg::*;

    localparam int NB = int'(BLOCK_SIZE);

    logic clk_p   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk_p = ~clk_p;

    turbo_ext_interleaver_if bus();

    turbo_ext_interleaver #(
        .PI_STEP   (5),
        .PI_OFFSET (0)
    ) dut (
        .clk_p_i   (clk_p),
        .reset_n_i (reset_n),
        .bus_s     (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic signed [DATA_SIZE-1:0]  llr_v [NB];
    logic signed [INPUT_SIZE-1:0] sys_v [NB];
    logic signed [INPUT_SIZE-1:0] apr_v [NB];
    logic signed [INPUT_SIZE-1:0] out_v [NB];
    int                           exp_v [NB];
    int                           pi_order [NB];

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    // Smallest LLR whose floor(3*llr/4) equals t (sys = apr = 0).
    function automatic int llr_for(input int t);
        int t4;
        t4 = 4 * t;
        return (t4 >= 0) ? (t4 + 2) / 3 : t4 / 3;
    endfunction

    task automatic load_tagged();
        for (int k = 0; k < NB; k++) begin
            llr_v[k] = DATA_SIZE'(llr_for(k - 10));
            sys_v[k] = '0;
            apr_v[k] = '0;
        end
    endtask

    task automatic exp_interleave();
        for (int j = 0; j < NB; j++) exp_v[j] = pi_order[j] - 10;
    endtask

    task automatic check_block(input string tag, input int n);
        for (int j = 0; j < n; j++) begin
            check_eq($sformatf("%s[%0d]", tag, j), int'(out_v[j]), exp_v[j]);
        end
    endtask

    // Called at a negedge; returns at the negedge one cycle after the last accept.
    task automatic fill_block(input logic m, input int gap, input logic hold_valid);
        int   k   = 0;
        int   cyc = 0;
        logic acc;
        while (k < NB && cyc < 2000) begin
            bus.in_valid_i = ((cyc % gap) == 0);
            bus.llr_i      = llr_v[k];
            bus.sys_i      = sys_v[k];
            bus.apr_i      = apr_v[k];
            bus.mode_i     = (k == 0) ? m : ~m;
            acc = bus.in_valid_i && bus.in_ready_o;
            @(posedge clk_p);
            if (acc) k++;
            cyc++;
            @(negedge clk_p);
        end
        check_eq("fill_beats", k, NB);
        bus.in_valid_i = hold_valid;
        check_eq("valid_before_latency", int'(bus.out_valid_o), 0);
        check_eq("in_ready_drain_entry", int'(bus.in_ready_o), 0);
        @(posedge clk_p);
        @(negedge clk_p);
    endtask

    // pat 0: ready always high; pat 1: ready pattern 1,0,0,1 repeating.
    task automatic drain_block(input int pat, input int n_max);
        int   j      = 0;
        int   cyc    = 0;
        logic rdy;
        logic stalled = 1'b0;
        logic signed [INPUT_SIZE-1:0] held_ext = '0;
        logic held_last = 1'b0;
        check_eq("first_valid_latency", int'(bus.out_valid_o), 1);
        check_eq("busy_in_drain", int'(bus.busy_o), 1);
        while (j < n_max && cyc < 400) begin
            check_eq("in_ready_in_drain", int'(bus.in_ready_o), 0);
            if (stalled) begin
                check_eq("hold_valid", int'(bus.out_valid_o), 1);
                check_eq("hold_ext", int'(bus.ext_o), int'(held_ext));
                check_eq("hold_last", int'(bus.out_last_o), int'(held_last));
            end
            rdy = (pat == 0) || ((cyc % 4) == 0) || ((cyc % 4) == 3);
            bus.out_ready_i = rdy;
            if (bus.out_valid_o && rdy) begin
                out_v[j] = bus.ext_o;
                check_eq($sformatf("last_flag[%0d]", j), int'(bus.out_last_o), int'(j == NB - 1));
                j++;
            end
            stalled   = bus.out_valid_o && !rdy;
            held_ext  = bus.ext_o;
            held_last = bus.out_last_o;
            @(posedge clk_p);
            cyc++;
            @(negedge clk_p);
        end
        bus.in_valid_i = 1'b0;
        check_eq("drain_beats", j, n_max);
        if (pat == 0) check_eq("drain_cycles", cyc, n_max);
        if (n_max == NB) begin
            check_eq("valid_after_last", int'(bus.out_valid_o), 0);
            check_eq("busy_after_last", int'(bus.busy_o), 0);
            check_eq("in_ready_after_last", int'(bus.in_ready_o), 1);
        end
    endtask

    initial begin
        pi_order = '{0, 5, 10, 15, 20, 4, 9, 14, 19, 3, 8, 13, 18, 2, 7, 12, 17, 1, 6, 11, 16};
        bus.mode_i      = 1'b0;
        bus.llr_i       = '0;
        bus.sys_i       = '0;
        bus.apr_i       = '0;
        bus.in_valid_i  = 1'b0;
        bus.out_ready_i = 1'b0;

        repeat (3) @(negedge clk_p);
        check_eq("rst_in_ready", int'(bus.in_ready_o), 1);
        check_eq("rst_out_valid", int'(bus.out_valid_o), 0);
        check_eq("rst_out_last", int'(bus.out_last_o), 0);
        check_eq("rst_busy", int'(bus.busy_o), 0);
        check_eq("rst_ext", int'(bus.ext_o), 0);
        reset_n = 1'b1;
        @(negedge clk_p);

        // Arithmetic vectors placed at beats k with pi(k) = 0..4 (deinterleave).
        for (int k = 0; k < NB; k++) begin
            llr_v[k] = '0; sys_v[k] = '0; apr_v[k] = '0; exp_v[k] = 0;
        end
        llr_v[0]  = 10'sd7;    sys_v[0]  = 5'sd2;  apr_v[0]  = 5'sd1;  exp_v[0] = 3;
        llr_v[17] = -10'sd20;  sys_v[17] = -5'sd4; apr_v[17] = 5'sd0;  exp_v[1] = -12;
        llr_v[13] = -10'sd1;   sys_v[13] = 5'sd0;  apr_v[13] = 5'sd0;  exp_v[2] = -1;
        llr_v[9]  = 10'sd100;  sys_v[9]  = 5'sd10; apr_v[9]  = 5'sd5;  exp_v[3] = 15;
        llr_v[5]  = -10'sd300; sys_v[5]  = 5'sd0;  apr_v[5]  = 5'sd0;  exp_v[4] = -16;
        fill_block(1'b1, 1, 1'b0);
        drain_block(0, NB);
        check_block("arith", NB);

        // Interleave of an index-tagged block.
        load_tagged();
        fill_block(1'b0, 1, 1'b0);
        drain_block(0, NB);
        exp_interleave();
        check_block("ilv", NB);

        // Feed the interleaved block back through deinterleave.
        for (int k = 0; k < NB; k++) begin
            llr_v[k] = DATA_SIZE'(llr_for(int'(out_v[k])));
            sys_v[k] = '0;
            apr_v[k] = '0;
        end
        fill_block(1'b1, 1, 1'b0);
        drain_block(0, NB);
        for (int j = 0; j < NB; j++) exp_v[j] = j - 10;
        check_block("rtrip", NB);

        // Output backpressure.
        load_tagged();
        fill_block(1'b0, 1, 1'b0);
        drain_block(1, NB);
        exp_interleave();
        check_block("bp", NB);

        // Sparse input valid, valid held high during drain.
        load_tagged();
        fill_block(1'b0, 3, 1'b1);
        drain_block(0, NB);
        exp_interleave();
        check_block("gap", NB);

        // Reset after 7 outputs, then a fresh block.
        load_tagged();
        fill_block(1'b0, 1, 1'b0);
        drain_block(0, 7);
        exp_interleave();
        check_block("pre_rst", 7);
        reset_n = 1'b0;
        #1;
        check_eq("midrst_out_valid", int'(bus.out_valid_o), 0);
        check_eq("midrst_in_ready", int'(bus.in_ready_o), 1);
        check_eq("midrst_busy", int'(bus.busy_o), 0);
        check_eq("midrst_last", int'(bus.out_last_o), 0);
        @(negedge clk_p);
        reset_n = 1'b1;
        @(negedge clk_p);
        check_eq("postrst_out_valid", int'(bus.out_valid_o), 0);
        fill_block(1'b0, 1, 1'b0);
        drain_block(0, NB);
        check_block("post_rst", NB);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
